// File: rtl/program_loader.sv
// Streams a program into instruction memory one registered byte write at a time,
// holding the CPU in reset until the image is complete and settled.
module program_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_BYTES  = 256,
    parameter int RESET_HOLD = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    input  logic                  reload,
    output logic                  ins_write,
    output logic [7:0]            instruction_write_data,
    output logic [ADDR_WIDTH-1:0] ins_addr,
    output logic                  cpu_reset,
    output logic [ADDR_WIDTH:0]   byte_count,
    output logic                  done,
    output logic                  error
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam int HW = $clog2(RESET_HOLD + 1);

    typedef enum logic [1:0] {
        LOAD,
        HOLD,
        RUN,
        ERR
    } state_e;

    state_e                state_q, state_d;
    logic [HW-1:0]         hold_q, hold_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  wr_q, wr_d;
    logic [7:0]            data_q, data_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    logic xfer;
    logic full;

    assign xfer = in_valid && (state_q == LOAD);
    assign full = (count_q == CW'(MAX_BYTES));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LOAD;
            hold_q  <= '0;
            count_q <= '0;
            wr_q    <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            count_q <= count_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        count_d = count_q;
        wr_d    = 1'b0;
        data_d  = data_q;
        addr_d  = addr_q;
        unique case (state_q)
            LOAD: begin
                // Capacity is checked before the pointer moves, so it never wraps.
                if (xfer) begin
                    if (full) begin
                        state_d = ERR;
                    end else begin
                        wr_d    = 1'b1;
                        data_d  = in_data;
                        addr_d  = count_q[ADDR_WIDTH-1:0];
                        count_d = count_q + CW'(1);
                        if (in_last) begin
                            state_d = HOLD;
                            hold_d  = '0;
                        end
                    end
                end
            end
            HOLD: begin
                if (hold_q == HW'(RESET_HOLD - 1)) begin
                    state_d = RUN;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            RUN, ERR: begin
                if (reload) begin
                    state_d = LOAD;
                    hold_d  = '0;
                    count_d = '0;
                    data_d  = '0;
                    addr_d  = '0;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    assign in_ready               = (state_q == LOAD);
    assign ins_write              = wr_q;
    assign instruction_write_data = data_q;
    assign ins_addr               = addr_q;
    assign cpu_reset              = (state_q != RUN);
    assign byte_count             = count_q;
    assign done                   = (state_q == RUN);
    assign error                  = (state_q == ERR);

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes are queued at issue
// time and checked by an independent write monitor.
module tb_program_loader;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_last;
    logic          in_ready;
    logic          reload;
    logic          ins_write;
    logic [7:0]    instruction_write_data;
    logic [AW-1:0] ins_addr;
    logic          cpu_reset;
    logic [AW:0]   byte_count;
    logic          done;
    logic          error;

    int total = 0;
    int bad   = 0;

    logic [15:0] sb_q[$];

    program_loader #(
        .ADDR_WIDTH(AW),
        .MAX_BYTES (4),
        .RESET_HOLD(5)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .in_valid              (in_valid),
        .in_data               (in_data),
        .in_last               (in_last),
        .in_ready              (in_ready),
        .reload                (reload),
        .ins_write             (ins_write),
        .instruction_write_data(instruction_write_data),
        .ins_addr              (ins_addr),
        .cpu_reset             (cpu_reset),
        .byte_count            (byte_count),
        .done                  (done),
        .error                 (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (ins_write === 1'b1) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr=%0h data=%0h expected none",
                         ins_addr, instruction_write_data);
            end else begin
                chk("write_addr_data", {ins_addr, instruction_write_data},
                    {16'h0, sb_q.pop_front()});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        step();
    endtask

    task automatic send(input logic [7:0] d, input logic last,
                        input bit wr, input logic [7:0] addr);
        chk("in_ready_before_send", in_ready, 1);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        if (wr) sb_q.push_back({addr, d});
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_run();
        for (int i = 0; i < 40 && done !== 1'b1; i++) step();
        chk("reach_run", done, 1);
    endtask

    task automatic do_reload();
        reload = 1'b1;
        step();
        reload = 1'b0;
        chk("reload_cpu_reset", cpu_reset, 1);
        chk("reload_done", done, 0);
        chk("reload_count", byte_count, 0);
        chk("reload_in_ready", in_ready, 1);
        chk("reload_error", error, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_ins_write"}, ins_write, 0);
        chk({tag, "_data"}, instruction_write_data, 0);
        chk({tag, "_addr"}, ins_addr, 0);
        chk({tag, "_cpu_reset"}, cpu_reset, 1);
        chk({tag, "_count"}, byte_count, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        reload   = 1'b0;
        step();
        step();
        reset = 1'b0;
        check_reset_vals("rst");

        // Two-byte back-to-back load.
        send(8'hC9, 1'b0, 1'b1, 8'd0);
        chk("b2b_first_write", ins_write, 1);
        send(8'h0A, 1'b1, 1'b1, 8'd1);
        chk("b2b_second_write", ins_write, 1);
        chk("b2b_addr", ins_addr, 1);
        chk("b2b_in_ready_low", in_ready, 0);
        chk("b2b_count", byte_count, 2);
        for (int i = 0; i < 4; i++) step();
        chk("hold_last_cycle_cpu_reset", cpu_reset, 1);
        chk("hold_last_cycle_done", done, 0);
        step();
        chk("run_cpu_reset", cpu_reset, 0);
        chk("run_done", done, 1);
        chk("run_in_ready", in_ready, 0);
        step();
        step();
        chk("run_stable_done", done, 1);
        chk("run_stable_write", ins_write, 0);

        // Reload then a single-byte program.
        do_reload();
        send(8'h55, 1'b1, 1'b1, 8'd0);
        chk("reload_write_addr", ins_addr, 0);
        wait_run();

        // Gapped source.
        do_reload();
        send(8'h01, 1'b0, 1'b1, 8'd0);
        idle();
        chk("gap1_no_write", ins_write, 0);
        send(8'h02, 1'b0, 1'b1, 8'd1);
        idle();
        chk("gap2_no_write", ins_write, 0);
        send(8'h03, 1'b1, 1'b1, 8'd2);
        chk("gap_count", byte_count, 3);
        wait_run();

        // Overflow: five bytes without last, capacity four.
        do_reload();
        for (int i = 0; i < 4; i++) send(8'h10 + 8'(i), 1'b0, 1'b1, 8'(i));
        send(8'h14, 1'b0, 1'b0, 8'd0);
        chk("ovf_error", error, 1);
        chk("ovf_cpu_reset", cpu_reset, 1);
        chk("ovf_in_ready", in_ready, 0);
        chk("ovf_no_write", ins_write, 0);
        chk("ovf_count", byte_count, 4);
        step();
        step();
        chk("ovf_error_sticky", error, 1);
        chk("ovf_done", done, 0);

        // Exact capacity.
        do_reload();
        for (int i = 0; i < 4; i++)
            send(8'hA0 + 8'(i), (i == 3), 1'b1, 8'(i));
        chk("cap_no_error", error, 0);
        chk("cap_in_ready", in_ready, 0);
        wait_run();
        chk("cap_count", byte_count, 4);
        chk("cap_error_run", error, 0);

        // Reset during the second handshake.
        do_reload();
        send(8'hAA, 1'b0, 1'b1, 8'd0);
        in_valid = 1'b1;
        in_data  = 8'hBB;
        reset    = 1'b1;
        step();
        in_valid = 1'b0;
        reset    = 1'b0;
        check_reset_vals("midrst");
        step();
        chk("midrst_no_late_write", ins_write, 0);

        step();
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
